// File: rtl/aes_cbc_enc_ctrl.sv
// CBC/ECB block-mode controller in front of the AES encipher round datapath.
// Holds one block in flight: XOR with the chaining value, pulse the encipher, return ciphertext.
module aes_cbc_enc_ctrl #(
    parameter bit           CHAIN_EN   = 1'b1,
    parameter logic [127:0] IV_RST_VAL = 128'h0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         key_ready,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         enc_next_cmd,
    output logic [127:0] enc_block_msg,
    input  logic [127:0] enc_new_block,
    input  logic         enc_ready,
    output logic         iv_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e       state_q;
    logic [127:0] chain_q;
    logic [127:0] out_block_q;
    logic [127:0] msg_q;
    logic         iv_valid_q;
    logic         out_valid_q;
    logic         cmd_q;
    logic         iv_err_q;
    logic         accept;
    logic         busy;

    assign in_ready = (state_q == IDLE) & key_ready
                    & (iv_valid_q | ~CHAIN_EN)
                    & ~iv_load & ~clear;
    assign accept   = in_valid & in_ready;

    // Encipher is (or is about to be) busy; a clear here must wait it out.
    assign busy = (state_q == START) | (state_q == WAIT)
                | (state_q == DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            chain_q     <= IV_RST_VAL;
            out_block_q <= '0;
            msg_q       <= '0;
            iv_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cmd_q       <= 1'b0;
            iv_err_q    <= 1'b0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
            iv_valid_q  <= 1'b0;
            chain_q     <= IV_RST_VAL;
            iv_err_q    <= 1'b0;
            cmd_q       <= 1'b0;
            state_q     <= busy ? DRAIN : IDLE;
        end else begin
            if (iv_load && state_q != IDLE) begin
                iv_err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (iv_load) begin
                        chain_q    <= iv;
                        iv_valid_q <= 1'b1;
                    end else if (accept) begin
                        msg_q   <= CHAIN_EN ? (in_block ^ chain_q) : in_block;
                        cmd_q   <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    cmd_q   <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (enc_ready) begin
                        out_block_q <= enc_new_block;
                        if (CHAIN_EN) begin
                            chain_q <= enc_new_block;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (enc_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_block     = out_block_q;
    assign enc_next_cmd  = cmd_q;
    assign enc_block_msg = msg_q;
    assign iv_err        = iv_err_q;

endmodule

// File: tb/tb_aes_cbc_enc_ctrl.sv
// Bench for aes_cbc_enc_ctrl: CBC and ECB instances driven by fixed-latency
// encipher stand-ins; expected ciphertext comes from a chaining model.
module tb_aes_cbc_enc_ctrl;

    localparam int LAT = 51;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         key_ready = 1'b1;
    logic         iv_load = 1'b0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0;
    logic [127:0] in_block = '0;
    logic         out_ready = 1'b0;

    logic         in_ready  [2];
    logic         out_valid [2];
    logic [127:0] out_block [2];
    logic         enc_cmd   [2];
    logic [127:0] enc_msg   [2];
    logic [127:0] enc_res   [2];
    logic         enc_rdy   [2];
    logic         iv_err    [2];

    int           enc_cnt   [2];
    logic [127:0] enc_lat   [2];
    int unsigned  cmd_cnt   [2] = '{0, 0};
    int unsigned  viol      [2] = '{0, 0};

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [127:0] chain_m = '0;

    always #5 clk = ~clk;

    aes_cbc_enc_ctrl #(.CHAIN_EN(1'b1), .IV_RST_VAL(128'h0)) u_cbc (
        .clk(clk), .reset_n(reset_n), .clear(clear), .key_ready(key_ready),
        .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_block(in_block), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_block(out_block[0]), .enc_next_cmd(enc_cmd[0]),
        .enc_block_msg(enc_msg[0]), .enc_new_block(enc_res[0]),
        .enc_ready(enc_rdy[0]), .iv_err(iv_err[0])
    );

    aes_cbc_enc_ctrl #(.CHAIN_EN(1'b0), .IV_RST_VAL(128'h0)) u_ecb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .key_ready(key_ready),
        .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_block(in_block), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_block(out_block[1]), .enc_next_cmd(enc_cmd[1]),
        .enc_block_msg(enc_msg[1]), .enc_new_block(enc_res[1]),
        .enc_ready(enc_rdy[1]), .iv_err(iv_err[1])
    );

    function automatic logic [127:0] enc_f(input logic [127:0] x);
        return ({x[94:0], x[127:95]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0)
               + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    // Stand-in encipher: ready drops after the pulse, returns LAT+1 edges later.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                enc_rdy[i] <= 1'b1;
                enc_cnt[i] <= 0;
                enc_res[i] <= '0;
            end else if (enc_cmd[i]) begin
                if (enc_cnt[i] != 0) viol[i] <= viol[i] + 1;
                cmd_cnt[i] <= cmd_cnt[i] + 1;
                enc_cnt[i] <= LAT;
                enc_rdy[i] <= 1'b0;
                enc_lat[i] <= enc_msg[i];
            end else if (enc_cnt[i] != 0) begin
                if (enc_msg[i] !== enc_lat[i]) viol[i] <= viol[i] + 1;
                enc_cnt[i] <= enc_cnt[i] - 1;
                if (enc_cnt[i] == 1) begin
                    enc_rdy[i] <= 1'b1;
                    enc_res[i] <= enc_f(enc_lat[i]);
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] model_cbc(input logic [127:0] pt);
        chain_m = enc_f(pt ^ chain_m);
        return chain_m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 0; iv_load = 0; in_valid = 0; out_ready = 0; key_ready = 1;
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
        chain_m = '0;
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv = v; iv_load = 1;
        tick();
        iv_load = 0;
        chain_m = v;
    endtask

    task automatic send(input int d, input logic [127:0] pt);
        bit ok;
        ok = 0;
        in_block = pt; in_valid = 1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (in_ready[d] === 1'b1) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready[d]);
        end
    endtask

    task automatic recv(input int d, input int dly, output logic [127:0] blk);
        int n;
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 300) begin
            tick(); n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL recv_timeout: out_valid=%b required 1", out_valid[d]);
            blk = 'x;
        end else begin
            repeat (dly) tick();
            blk = out_block[d];
            out_ready = 1;
            tick();
            out_ready = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 7;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid[0]); end
        if (out_block[0] !== '0) begin errors++; $display("FAIL rst_out_block: got %h want 0", out_block[0]); end
        if (enc_cmd[0] !== 1'b0) begin errors++; $display("FAIL rst_next_cmd: got %b want 0", enc_cmd[0]); end
        if (enc_msg[0] !== '0) begin errors++; $display("FAIL rst_block_msg: got %h want 0", enc_msg[0]); end
        if (iv_err[0] !== 1'b0) begin errors++; $display("FAIL rst_iv_err: got %b want 0", iv_err[0]); end
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_in_ready_cbc: got %b want 0", in_ready[0]); end
        if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL rst_in_ready_ecb: got %b want 1", in_ready[1]); end
    endtask

    task automatic test_latency();
        logic [127:0] pt, v, exp, msg;
        int e;
        v = rnd128(); pt = rnd128();
        load_iv(v);
        msg = pt ^ chain_m;
        exp = model_cbc(pt);
        send(0, pt);
        checks += 6;
        if (enc_cmd[0] !== 1'b1) begin errors++; $display("FAIL lat_cmd_e0: got %b want 1", enc_cmd[0]); end
        if (enc_msg[0] !== msg) begin errors++; $display("FAIL lat_msg: got %h want %h", enc_msg[0], msg); end
        tick();
        if (enc_cmd[0] !== 1'b0) begin errors++; $display("FAIL lat_cmd_e1: got %b want 0", enc_cmd[0]); end
        e = 1;
        while (out_valid[0] !== 1'b1 && e < 200) begin
            tick(); e++;
        end
        if (e != 53) begin errors++; $display("FAIL lat_edges: got %0d want 53", e); end
        if (out_block[0] !== exp) begin errors++; $display("FAIL lat_block: got %h want %h", out_block[0], exp); end
        out_ready = 1;
        tick();
        out_ready = 0;
        #1;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL lat_next_accept: in_ready %b want 1", in_ready[0]); end
    endtask

    task automatic test_cbc_chain();
        logic [127:0] pt, exp, got;
        load_iv(rnd128());
        for (int k = 0; k < 4; k++) begin
            pt = rnd128();
            exp = model_cbc(pt);
            send(0, pt);
            recv(0, $urandom_range(0, 3), got);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL cbc_blk%0d: got %h want %h", k, got, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, exp, snap, got;
        int unsigned c0;
        bit bad;
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        while (out_valid[0] !== 1'b1 && enc_cnt[0] < 300) tick();
        snap = out_block[0];
        c0 = cmd_cnt[0];
        in_block = rnd128(); in_valid = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid[0] !== 1'b1 || out_block[0] !== snap || in_ready[0] !== 1'b0 || enc_cmd[0] !== 1'b0)
                bad = 1;
        end
        in_valid = 0;
        checks += 3;
        if (bad) begin errors++; $display("FAIL bp_hold: out_valid/out_block/in_ready changed, last %b %h %b", out_valid[0], out_block[0], in_ready[0]); end
        if (cmd_cnt[0] != c0) begin errors++; $display("FAIL bp_cmd: got %0d pulses want %0d", cmd_cnt[0], c0); end
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL bp_block: got %h want %h", got, exp); end
    endtask

    task automatic test_clear_wait();
        logic [127:0] pt, exp, got;
        bit bad;
        send(0, rnd128());
        repeat (11) tick();
        clear = 1;
        tick();
        clear = 0;
        tick();
        iv = rnd128(); iv_load = 1;
        tick();
        iv_load = 0;
        checks += 4;
        if (iv_err[0] !== 1'b1) begin errors++; $display("FAIL clr_drain_iv_err: got %b want 1", iv_err[0]); end
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) bad = 1;
            tick();
        end
        if (bad) begin errors++; $display("FAIL clr_drain_quiet: out_valid %b in_ready %b want 0 0", out_valid[0], in_ready[0]); end
        clear = 1;
        tick();
        clear = 0;
        if (iv_err[0] !== 1'b0) begin errors++; $display("FAIL clr_iv_err: got %b want 0", iv_err[0]); end
        chain_m = '0;
        load_iv(rnd128());
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL clr_after: got %h want %h", got, exp); end
    endtask

    task automatic test_clear_start();
        logic [127:0] pt, exp, got;
        int unsigned c0;
        bit bad;
        load_iv(rnd128());
        c0 = cmd_cnt[0];
        send(0, rnd128());
        clear = 1;
        tick();
        clear = 0;
        checks += 4;
        if (enc_cmd[0] !== 1'b0) begin errors++; $display("FAIL cs_cmd_end: got %b want 0", enc_cmd[0]); end
        tick();
        if (cmd_cnt[0] != c0 + 1) begin errors++; $display("FAIL cs_pulse: got %0d pulses want %0d", cmd_cnt[0], c0 + 1); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid[0] !== 1'b0) bad = 1;
            tick();
        end
        if (bad) begin errors++; $display("FAIL cs_no_out: out_valid %b want 0", out_valid[0]); end
        load_iv(rnd128());
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL cs_after: got %h want %h", got, exp); end
    endtask

    task automatic test_iv_err();
        logic [127:0] pt, exp, got;
        load_iv(rnd128());
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        repeat (5) tick();
        iv = rnd128(); iv_load = 1;
        tick();
        iv_load = 0;
        checks += 5;
        if (iv_err[0] !== 1'b1) begin errors++; $display("FAIL ive_set: got %b want 1", iv_err[0]); end
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL ive_blk1: got %h want %h", got, exp); end
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        recv(0, 1, got);
        if (got !== exp) begin errors++; $display("FAIL ive_blk2: got %h want %h", got, exp); end
        if (iv_err[0] !== 1'b1) begin errors++; $display("FAIL ive_sticky: got %b want 1", iv_err[0]); end
        clear = 1;
        tick();
        clear = 0;
        if (iv_err[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL ive_clear: iv_err %b in_ready %b want 0 0", iv_err[0], in_ready[0]);
        end
        chain_m = '0;
    endtask

    task automatic test_iv_priority();
        logic [127:0] pt, b, exp, got;
        load_iv(rnd128());
        b = rnd128(); pt = rnd128();
        iv = b; iv_load = 1; in_block = pt; in_valid = 1;
        tick();
        iv_load = 0; in_valid = 0;
        chain_m = b;
        checks += 2;
        if (enc_cmd[0] !== 1'b0) begin errors++; $display("FAIL ivp_no_accept: next_cmd %b want 0", enc_cmd[0]); end
        exp = model_cbc(pt);
        send(0, pt);
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL ivp_block: got %h want %h", got, exp); end
    endtask

    task automatic test_key_ready();
        logic [127:0] pt, exp, got;
        key_ready = 0;
        #1;
        checks += 4;
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL kr_gate: in_ready %b want 0", in_ready[0]); end
        key_ready = 1;
        pt = rnd128();
        exp = model_cbc(pt);
        send(0, pt);
        key_ready = 0;
        recv(0, 0, got);
        if (got !== exp) begin errors++; $display("FAIL kr_midblock: got %h want %h", got, exp); end
        #1;
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL kr_after: in_ready %b want 0", in_ready[0]); end
        key_ready = 1;
        #1;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL kr_restore: in_ready %b want 1", in_ready[0]); end
    endtask

    task automatic test_async_reset();
        send(0, rnd128());
        repeat (4) tick();
        iv_load = 1;
        tick();
        iv_load = 0;
        #2;
        reset_n = 0;
        #1;
        checks += 2;
        if (out_valid[0] !== 1'b0 || enc_cmd[0] !== 1'b0 || enc_msg[0] !== '0 || iv_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_vals: out_valid %b cmd %b msg %h iv_err %b want all 0", out_valid[0], enc_cmd[0], enc_msg[0], iv_err[0]);
        end
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", in_ready[0]); end
        tick();
        reset_n = 1;
        tick();
        chain_m = '0;
    endtask

    task automatic test_ecb();
        logic [127:0] pt, got1, got2;
        do_reset();
        pt = rnd128();
        send(1, pt);
        recv(1, 0, got1);
        send(1, pt);
        recv(1, 2, got2);
        checks += 4;
        if (got1 !== enc_f(pt)) begin errors++; $display("FAIL ecb_blk1: got %h want %h", got1, enc_f(pt)); end
        if (got2 !== got1) begin errors++; $display("FAIL ecb_repeat: got %h want %h", got2, got1); end
        if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL ecb_cbc_idle: cbc in_ready %b want 0", in_ready[0]); end
        if (viol[0] != 0 || viol[1] != 0) begin
            errors++; $display("FAIL enc_protocol: violations %0d %0d want 0 0", viol[0], viol[1]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_cbc_chain();
        test_backpressure();
        test_clear_wait();
        test_clear_start();
        test_iv_err();
        test_iv_priority();
        test_key_ready();
        test_async_reset();
        test_ecb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
